// File: rtl/adc_clk_gen.sv
// rtl/adc_clk_gen.sv - ADC sample-clock generator: lock qualification, programmable
// per-channel divided clocks and sample strobes with period-aligned reconfiguration.
module adc_clk_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_WAIT   = 1024,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic                      pll_lock,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic [CHANNELS*DIV_W-1:0] cfg_phase,
    input  logic [CHANNELS-1:0]       cfg_en,
    output logic                      cfg_err,
    output logic                      locked,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       sample_stb
);

    localparam int                LOCK_W    = $clog2(LOCK_WAIT + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WAIT - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_TWO   = DIV_W'(2);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [LOCK_W-1:0]         lock_cnt, lock_cnt_nxt;
    logic [DIV_W-1:0]          cnt, cnt_nxt;

    logic [DIV_W-1:0]          act_div, pend_div;
    logic [CHANNELS*DIV_W-1:0] act_phase, pend_phase;
    logic [CHANNELS-1:0]       act_en, pend_en;
    logic                      pending;

    logic                      transfer;
    logic                      cfg_ok;
    logic                      commit;
    logic                      run_ok;
    logic                      period_end;
    logic [CHANNELS-1:0]       clk_nxt, stb_nxt;

    assign locked     = (state == RUN);
    assign cfg_ready  = (state == RUN) && !pending;
    assign transfer   = cfg_valid && cfg_ready;
    assign period_end = (cnt == act_div - DIV_ONE);
    assign run_ok     = (state == RUN) && pll_lock;
    // Outside RUN there is no period to align to, so a held config lands at once.
    assign commit     = pending && ((state == WAIT_LOCK) || period_end);

    always_comb begin
        cfg_ok = (cfg_div >= DIV_TWO);
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_phase[i*DIV_W +: DIV_W] >= cfg_div) begin
                cfg_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        cnt_nxt      = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (!pll_lock) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = RUN;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                end
            end
            RUN: begin
                lock_cnt_nxt = '0;
                if (!pll_lock) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (period_end) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + DIV_ONE;
                end
            end
            default: begin
                state_nxt    = WAIT_LOCK;
                lock_cnt_nxt = '0;
                cnt_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // A channel being disabled by the committing config is muted on the commit edge itself.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_W-1:0] ph;
        logic [DIV_W-1:0] loc;
        logic             en;
        assign ph          = act_phase[i*DIV_W +: DIV_W];
        assign loc         = (cnt >= ph) ? (cnt - ph) : (cnt + act_div - ph);
        assign en          = act_en[i] && (!commit || pend_en[i]);
        assign clk_nxt[i]  = run_ok && en && (loc < (act_div >> 1));
        assign stb_nxt[i]  = run_ok && en && (loc == '0);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            act_div    <= DIV_W'(DEFAULT_DIV);
            act_phase  <= '0;
            act_en     <= '1;
            pend_div   <= '0;
            pend_phase <= '0;
            pend_en    <= '0;
            pending    <= 1'b0;
            clk_out    <= '0;
            sample_stb <= '0;
            cfg_err    <= 1'b0;
        end else begin
            clk_out    <= clk_nxt;
            sample_stb <= stb_nxt;
            cfg_err    <= transfer && !cfg_ok;
            if (commit) begin
                act_div   <= pend_div;
                act_phase <= pend_phase;
                act_en    <= pend_en;
                pending   <= 1'b0;
            end
            if (transfer && cfg_ok) begin
                pend_div   <= cfg_div;
                pend_phase <= cfg_phase;
                pend_en    <= cfg_en;
                pending    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_clk_gen.sv
// tb/tb_adc_clk_gen.sv - self-checking bench for adc_clk_gen: directed literal checks
// plus randomized traffic compared every cycle against a behavioural model.
module tb_adc_clk_gen;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int LW = 16;

    logic           clk;
    logic           reset;
    logic           pll_lock;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [DW-1:0]  cfg_div;
    logic [CH*DW-1:0] cfg_phase;
    logic [CH-1:0]  cfg_en;
    logic           cfg_err;
    logic           locked;
    logic [CH-1:0]  clk_out;
    logic [CH-1:0]  sample_stb;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 0;

    adc_clk_gen #(
        .CHANNELS(CH), .DIV_W(DW), .LOCK_WAIT(LW), .DEFAULT_DIV(8)
    ) dut (
        .clkin(clk), .reset(reset), .pll_lock(pll_lock),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
        .cfg_phase(cfg_phase), .cfg_en(cfg_en), .cfg_err(cfg_err),
        .locked(locked), .clk_out(clk_out), .sample_stb(sample_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: running flag, consecutive-lock count, position in period.
    bit          m_run, m_pend, m_err;
    int          m_lock, m_pos, m_div, p_div;
    int          m_ph[CH];
    int          p_ph[CH];
    bit [CH-1:0] m_en, p_en, m_clk, m_stb;

    always @(posedge clk) begin
        bit xfer, ok, commit;
        int c;
        if (reset) begin
            m_run = 0; m_pend = 0; m_err = 0; m_lock = 0; m_pos = 0; m_div = 8;
            m_en = '1; m_clk = '0; m_stb = '0;
            for (int i = 0; i < CH; i++) m_ph[i] = 0;
        end else begin
            xfer = cfg_valid && m_run && !m_pend;
            ok = (cfg_div >= 2);
            for (int i = 0; i < CH; i++) if (cfg_phase[i*DW +: DW] >= cfg_div) ok = 0;
            commit = m_pend && (!m_run || m_pos == m_div - 1);
            for (int i = 0; i < CH; i++) begin
                c = (m_pos - m_ph[i] + m_div) % m_div;
                m_clk[i] = m_run && pll_lock && m_en[i] && !(commit && !p_en[i]) && (c < m_div / 2);
                m_stb[i] = m_run && pll_lock && m_en[i] && !(commit && !p_en[i]) && (c == 0);
            end
            m_err = xfer && !ok;
            if (m_run && pll_lock) begin
                m_pos = commit ? 0 : (m_pos + 1) % m_div;
            end else if (m_run) begin
                m_run = 0; m_pos = 0;
            end else begin
                m_pos = 0;
                m_lock = pll_lock ? m_lock + 1 : 0;
                if (m_lock == LW) begin m_run = 1; m_lock = 0; end
            end
            if (commit) begin
                m_div = p_div; m_en = p_en; m_pend = 0;
                for (int i = 0; i < CH; i++) m_ph[i] = p_ph[i];
            end
            if (xfer && ok) begin
                p_div = int'(cfg_div); p_en = cfg_en; m_pend = 1;
                for (int i = 0; i < CH; i++) p_ph[i] = int'(cfg_phase[i*DW +: DW]);
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] act, exp;
        if (chk_on) begin
            exp = {m_run, m_run && !m_pend, m_err, m_clk, m_stb};
            act = {locked, cfg_ready, cfg_err, clk_out, sample_stb};
            n_checks++;
            if (act !== exp) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t got=%b want=%b (locked,ready,err,clk[1:0],stb[1:0])",
                         $time, act, exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic capture(input int n, output logic [15:0] c0, output logic [15:0] s0,
                           output logic [15:0] c1, output logic [15:0] s1);
        c0 = '0; s0 = '0; c1 = '0; s1 = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            c0[k] = clk_out[0]; s0[k] = sample_stb[0];
            c1[k] = clk_out[1]; s1[k] = sample_stb[1];
        end
    endtask

    task automatic offer(input int div, input int ph0, input int ph1, input logic [1:0] en);
        cfg_valid = 1'b1;
        cfg_div = DW'(div);
        cfg_phase = {DW'(ph1), DW'(ph0)};
        cfg_en = en;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 64 && !cfg_ready; k++) tick();
        check("wait_ready", {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] c0, s0, c1, s1;
        reset = 1'b1; pll_lock = 1'b0; cfg_valid = 1'b0;
        cfg_div = 16'd8; cfg_phase = '0; cfg_en = 2'b11;
        tick(); chk_on = 1; tick();
        check("reset_outs", {25'd0, locked, cfg_ready, cfg_err, clk_out, sample_stb}, 32'd0);

        reset = 1'b0; pll_lock = 1'b1;
        repeat (15) tick();
        check("lock_early", {31'd0, locked}, 32'd0);
        tick();
        check("lock_rise", {31'd0, locked}, 32'd1);
        capture(16, c0, s0, c1, s1);
        check("div8_clk0", {16'd0, c0}, 32'h0F0F);
        check("div8_stb0", {16'd0, s0}, 32'h0101);
        check("div8_clk1", {16'd0, c1}, 32'h0F0F);

        repeat (2) tick();
        offer(5, 0, 0, 2'b11);
        repeat (4) tick();
        check("ready_hold", {31'd0, cfg_ready}, 32'd0);
        tick();
        check("ready_commit", {31'd0, cfg_ready}, 32'd1);
        capture(10, c0, s0, c1, s1);
        check("div5_clk0", {16'd0, c0}, 32'h0063);
        check("div5_stb0", {16'd0, s0}, 32'h0021);

        offer(8, 0, 3, 2'b11);
        wait_ready();
        capture(8, c0, s0, c1, s1);
        check("ph_clk0", {16'd0, c0}, 32'h000F);
        check("ph_stb0", {16'd0, s0}, 32'h0001);
        check("ph_clk1", {16'd0, c1}, 32'h0078);
        check("ph_stb1", {16'd0, s1}, 32'h0008);

        offer(1, 0, 0, 2'b11);
        check("err_div1", {31'd0, cfg_err}, 32'd1);
        tick();
        check("err_once", {31'd0, cfg_err}, 32'd0);
        offer(4, 4, 0, 2'b11);
        check("err_phase", {31'd0, cfg_err}, 32'd1);
        check("ready_after_err", {31'd0, cfg_ready}, 32'd1);

        offer(6, 0, 0, 2'b11);
        pll_lock = 1'b0;
        tick();
        check("lockloss_outs", {27'd0, locked, clk_out, sample_stb}, 32'd0);
        pll_lock = 1'b1;
        repeat (16) tick();
        check("relock", {31'd0, locked}, 32'd1);
        capture(12, c0, s0, c1, s1);
        check("relock_div6_clk", {16'd0, c0}, 32'h01C7);
        check("relock_div6_stb", {16'd0, s0}, 32'h0041);

        reset = 1'b1; tick(); reset = 1'b0;
        check("reset_mid", {31'd0, locked}, 32'd0);
        repeat (10) tick();
        pll_lock = 1'b0; tick(); pll_lock = 1'b1;
        repeat (15) tick();
        check("glitch_early", {31'd0, locked}, 32'd0);
        tick();
        check("glitch_rise", {31'd0, locked}, 32'd1);
        capture(16, c0, s0, c1, s1);
        check("reset_div8_clk", {16'd0, c0}, 32'h0F0F);

        for (int n = 0; n < 4000; n++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div = DW'($urandom_range(0, 12));
            for (int i = 0; i < CH; i++) cfg_phase[i*DW +: DW] = DW'($urandom_range(0, 12));
            cfg_en = 2'($urandom_range(0, 3));
            pll_lock = ($urandom_range(0, 63) != 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
